// File: rtl/mem_stage_hs.sv
// MEM stage of the 5-stage MIPS core: latches the EX->MEM bus, runs the split
// address/data handshake to data memory, aligns load data and feeds WB and ID forwarding.
module mem_stage_hs #(
  parameter int IN_WD  = 111,
  parameter int OUT_WD = 70
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [IN_WD-1:0]  ex_to_mem_bus,
  output logic [OUT_WD-1:0] mem_to_wb_bus,
  output logic [37:0]       mem_to_id_bus,
  output logic              stallreq_for_mem,
  output logic              mem_addr_err,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_BS = 3'd1;
  localparam logic [2:0] OP_BU = 3'd2;
  localparam logic [2:0] OP_HS = 3'd3;
  localparam logic [2:0] OP_HU = 3'd4;
  localparam logic       STOP  = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  logic [IN_WD-1:0] bus_r;
  logic             done_r;
  logic [31:0]      rdata_r;
  state_t           state_r, state_nx;

  logic [2:0]  mem_op_s;
  logic [31:0] store_data_s, ex_pc_s, ex_result_s, load_data_s, rf_wdata_s;
  logic        en_s, sel_rf_res_s, rf_we_s, rf_we_out_s;
  logic [3:0]  wen_s;
  logic [4:0]  rf_waddr_s;
  logic        is_byte_s, is_half_s, is_word_s, store_s, misaligned_s, access_ok_s;
  logic        unused_stall_bits;

  assign {mem_op_s, store_data_s, ex_pc_s, en_s, wen_s, sel_rf_res_s,
          rf_we_s, rf_waddr_s, ex_result_s} = bus_r;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  function automatic logic [31:0] align_load(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_BS:   res = {{24{b[7]}}, b};
      OP_BU:   res = {24'h000000, b};
      OP_HS:   res = {{16{h[15]}}, h};
      OP_HU:   res = {16'h0000, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_strobe(input logic byte_op, input logic half_op,
                                              input logic [1:0] lo);
    logic [3:0] s;
    if (byte_op) begin
      s = 4'b0001 << lo;
    end else if (half_op) begin
      s = lo[1] ? 4'b1100 : 4'b0011;
    end else begin
      s = 4'b1111;
    end
    return s;
  endfunction

  assign is_byte_s    = (mem_op_s == OP_BS) || (mem_op_s == OP_BU);
  assign is_half_s    = (mem_op_s == OP_HS) || (mem_op_s == OP_HU);
  assign is_word_s    = ~is_byte_s & ~is_half_s;
  assign store_s      = en_s & (wen_s != 4'b0000);
  assign misaligned_s = en_s & ((is_half_s & ex_result_s[0]) |
                                (is_word_s & (ex_result_s[1:0] != 2'b00)));
  assign access_ok_s  = en_s & ~misaligned_s;

  // Input register, done flag and captured load data
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r   <= '0;
      done_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else if (stall[3] == STOP && stall[4] != STOP) begin
      bus_r   <= '0;
      done_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else if (stall[3] != STOP) begin
      bus_r   <= ex_to_mem_bus;
      done_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else if (state_r == WAIT && data_data_ok) begin
      done_r  <= 1'b1;
      rdata_r <= align_load(mem_op_s, ex_result_s[1:0], data_rdata);
    end else begin
      bus_r   <= bus_r;
      done_r  <= done_r;
      rdata_r <= rdata_r;
    end
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and request; the IDLE cycle already presents the request
  always_comb begin
    state_nx = state_r;
    data_req = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_ok_s && !done_r) begin
          data_req = 1'b1;
          state_nx = data_addr_ok ? WAIT : REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          state_nx = WAIT;
        end else begin
          state_nx = REQ;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stallreq_for_mem = access_ok_s & ~done_r & ~((state_r == WAIT) & data_data_ok);
  assign mem_addr_err     = misaligned_s;
  assign data_wr          = store_s;
  assign data_addr        = ex_result_s;
  assign data_wstrb       = store_s ? store_strobe(is_byte_s, is_half_s, ex_result_s[1:0])
                                    : 4'b0000;
  assign data_wdata       = is_byte_s ? {4{store_data_s[7:0]}} :
                            is_half_s ? {2{store_data_s[15:0]}} : store_data_s;

  // Once the access is done the captured data survives changes on data_rdata
  assign load_data_s   = done_r ? rdata_r : align_load(mem_op_s, ex_result_s[1:0], data_rdata);
  assign rf_wdata_s    = sel_rf_res_s ? load_data_s : ex_result_s;
  assign rf_we_out_s   = rf_we_s & ~misaligned_s;
  assign mem_to_wb_bus = {ex_pc_s, rf_we_out_s, rf_waddr_s, rf_wdata_s};
  assign mem_to_id_bus = {rf_we_out_s, rf_waddr_s, rf_wdata_s};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: ALU pass-through, loads/stores with multi-cycle
// handshakes, WB-side hold without re-issue, misalignment and reset during an access.
module tb_mem_stage_hs;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_stop;
  logic [5:0]   stall;
  logic [110:0] ex_to_mem_bus;
  logic [69:0]  mem_to_wb_bus;
  logic [37:0]  mem_to_id_bus;
  logic         stallreq_for_mem, mem_addr_err, data_req, data_wr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr, data_wdata, data_rdata;
  logic         data_addr_ok, data_data_ok;

  int n_checks = 0;
  int n_fail   = 0;
  int reqs, stalls;
  logic [31:0] wd_ok;
  logic        st_ok;

  always #5 clk = ~clk;

  // Pipeline control freezes MEM (and WB) while MEM asks for it or WB is held.
  assign stall = (stallreq_for_mem || wb_stop) ? 6'b011111 : 6'b000000;

  mem_stage_hs dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_to_id_bus(mem_to_id_bus),
    .stallreq_for_mem(stallreq_for_mem), .mem_addr_err(mem_addr_err),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [110:0] mk(input logic [2:0] op, input logic [31:0] sd,
                                      input logic [31:0] pc, input logic en,
                                      input logic [3:0] wen, input logic sel,
                                      input logic we, input logic [4:0] wa,
                                      input logic [31:0] res);
    return {op, sd, pc, en, wen, sel, we, wa, res};
  endfunction

  // Load one instruction into the stage; returns 2 time units after the edge.
  task automatic latch(input logic [110:0] b);
    ex_to_mem_bus = b;
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
    #1;
  endtask

  // Drive addr_ok in cycle aok and data_ok in cycle dok, sampling each cycle.
  task automatic access(input int aok, input int dok, input logic [31:0] rd,
                        output int nreq, output int nstall,
                        output logic [31:0] wd, output logic st);
    nreq = 0; nstall = 0; wd = 32'h0; st = 1'b1;
    for (int k = 0; k <= dok; k++) begin
      data_addr_ok = (k == aok);
      data_data_ok = (k == dok);
      data_rdata   = rd;
      @(negedge clk);
      if (data_req) nreq++;
      if (k < dok && stallreq_for_mem) nstall++;
      if (k == dok) begin
        wd = mem_to_wb_bus[31:0];
        st = stallreq_for_mem;
      end
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_stop = 1'b0; ex_to_mem_bus = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb", mem_to_wb_bus, 70'h0);
    chk("rst_id", {32'h0, mem_to_id_bus}, 70'h0);
    chk("rst_ctl", {66'h0, data_req, data_wr, stallreq_for_mem, mem_addr_err}, 70'h0);
    chk("rst_strb", {66'h0, data_wstrb}, 70'h0);
    chk("rst_addr", {38'h0, data_addr}, 70'h0);
    rst = 1'b0;

    // ALU result passes straight through
    latch(mk(3'd0, 32'h0, 32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234));
    chk("alu_wb", mem_to_wb_bus, {32'hBFC00000, 1'b1, 5'd5, 32'h00001234});
    chk("alu_id", {32'h0, mem_to_id_bus}, {32'h0, 1'b1, 5'd5, 32'h00001234});
    chk("alu_req", {69'h0, data_req}, 70'h0);
    chk("alu_stall", {69'h0, stallreq_for_mem}, 70'h0);

    // LB at 0x1003: addr_ok in second request cycle, data_ok two cycles later
    latch(mk(3'd1, 32'h0, 32'hBFC00004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h1003));
    chk("lb_addr", {38'h0, data_addr}, {38'h0, 32'h1003});
    chk("lb_wr", {66'h0, data_wr, data_wstrb}, 70'h0);
    access(1, 3, 32'h80AABBCC, reqs, stalls, wd_ok, st_ok);
    chk("lb_reqs", 70'(reqs), 70'd2);
    chk("lb_stalls", 70'(stalls), 70'd3);
    chk("lb_data", {38'h0, wd_ok}, {38'h0, 32'hFFFFFF80});
    chk("lb_stall_ok", {69'h0, st_ok}, 70'h0);
    chk("lb_after_req", {69'h0, data_req}, 70'h0);

    // LBU, fastest handshake
    latch(mk(3'd2, 32'h0, 32'hBFC00008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h1003));
    access(0, 1, 32'h80AABBCC, reqs, stalls, wd_ok, st_ok);
    chk("lbu_reqs", 70'(reqs), 70'd1);
    chk("lbu_stalls", 70'(stalls), 70'd1);
    chk("lbu_data", {38'h0, wd_ok}, {38'h0, 32'h00000080});

    // LH signed, upper half
    latch(mk(3'd3, 32'h0, 32'hBFC0000C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h6002));
    access(0, 1, 32'h80011234, reqs, stalls, wd_ok, st_ok);
    chk("lh_data", {38'h0, wd_ok}, {38'h0, 32'hFFFF8001});

    // LHU, lower half
    latch(mk(3'd4, 32'h0, 32'hBFC00010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h6000));
    access(0, 1, 32'h8001F00D, reqs, stalls, wd_ok, st_ok);
    chk("lhu_data", {38'h0, wd_ok}, {38'h0, 32'h0000F00D});

    // SH at 0x2002
    latch(mk(3'd3, 32'h0000BEEF, 32'hBFC00014, 1'b1, 4'b1100, 1'b0, 1'b0, 5'd0, 32'h2002));
    chk("sh_wr", {69'h0, data_wr}, 70'h1);
    chk("sh_strb", {66'h0, data_wstrb}, 70'hC);
    chk("sh_wdata", {38'h0, data_wdata}, {38'h0, 32'hBEEFBEEF});
    chk("sh_rfwe", {69'h0, mem_to_wb_bus[37]}, 70'h0);
    access(0, 2, 32'h0, reqs, stalls, wd_ok, st_ok);
    chk("sh_reqs", 70'(reqs), 70'd1);
    chk("sh_stalls", 70'(stalls), 70'd2);
    chk("sh_stall_ok", {69'h0, st_ok}, 70'h0);

    // SB at offset 1
    latch(mk(3'd2, 32'h000000A5, 32'hBFC00018, 1'b1, 4'b0001, 1'b0, 1'b0, 5'd0, 32'h2001));
    chk("sb_strb", {66'h0, data_wstrb}, 70'h2);
    chk("sb_wdata", {38'h0, data_wdata}, {38'h0, 32'hA5A5A5A5});
    access(0, 1, 32'h0, reqs, stalls, wd_ok, st_ok);

    // LW completes while WB holds the stage: one handshake only, data kept
    latch(mk(3'd0, 32'h0, 32'hBFC0001C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h4000));
    wb_stop = 1'b1;
    access(0, 1, 32'hCAFEF00D, reqs, stalls, wd_ok, st_ok);
    chk("lw_data_ok", {38'h0, wd_ok}, {38'h0, 32'hCAFEF00D});
    for (int i = 0; i < 3; i++) begin
      data_rdata = 32'hDEADBEEF;
      @(negedge clk);
      if (data_req) reqs++;
      chk("lw_hold_data", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hCAFEF00D});
      chk("lw_hold_stall", {69'h0, stallreq_for_mem}, 70'h0);
      @(posedge clk); #1;
    end
    chk("lw_reqs", 70'(reqs), 70'd1);
    wb_stop = 1'b0;
    @(posedge clk); #1;

    // Misaligned LH
    latch(mk(3'd3, 32'h0, 32'hBFC00020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h3001));
    chk("mis_err", {69'h0, mem_addr_err}, 70'h1);
    chk("mis_req", {69'h0, data_req}, 70'h0);
    chk("mis_rfwe", {69'h0, mem_to_wb_bus[37]}, 70'h0);
    chk("mis_stall", {69'h0, stallreq_for_mem}, 70'h0);
    @(posedge clk); #1;
    chk("mis_cleared", {69'h0, mem_addr_err}, 70'h0);

    // Reset while waiting for data
    latch(mk(3'd0, 32'h0, 32'hBFC00024, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h5000));
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    #1;
    chk("wait_stall", {69'h0, stallreq_for_mem}, 70'h1);
    chk("wait_req", {69'h0, data_req}, 70'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_req", {69'h0, data_req}, 70'h0);
    chk("rstw_wb", mem_to_wb_bus, 70'h0);
    chk("rstw_id", {32'h0, mem_to_id_bus}, 70'h0);
    chk("rstw_stall", {69'h0, stallreq_for_mem}, 70'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h12345678;
    #1;
    chk("late_ok_wb", mem_to_wb_bus, 70'h0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    #1;
    chk("late_ok_after", mem_to_wb_bus, 70'h0);
    chk("late_ok_req", {69'h0, data_req}, 70'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
